flag_unit: RTL and testbench
============================

Name: flag_unit

Overview:
- Producer side of the branch condition interface: holds the architectural Z/V/N flags that the PC/branch logic in ID consumes.
- Captures flags from the EX-stage ALU result under per-flag write enables.
- Evaluates the 3-bit branch condition code against the flags for the branch in ID.
- Raises a one-cycle branch hazard stall when a flag-writing instruction in EX would change the outcome. When BYPASS=1, it forwards the EX flags instead.

Parameters:
WIDTH, 16, ALU result width in bits
BYPASS, 0, 0 = stall the ID branch behind a flag writer in EX; 1 = forward EX flags to cond_met combinationally, never stall

Ports:
clk  in  1  clock, all state updates on the rising edge
rst_n  in  1  synchronous active-low reset
stall_in  in  1  global pipeline hold; while 1, EX does not commit
flush  in  1  squash the EX instruction this cycle (no flag write)
ex_valid  in  1  the EX stage holds a valid instruction
ex_flag_we  in  3  per-flag write enable: bit0 Z, bit1 V, bit2 N
ex_result  in  WIDTH  ALU result of the EX instruction
ex_ovf  in  1  signed overflow from the ALU
id_branch  in  1  ID holds a conditional branch (B or BR)
id_cond  in  3  condition code of the ID branch
flags  out  3  registered flags {N,V,Z}: bit0 Z, bit1 V, bit2 N
cond_met  out  1  the condition for id_cond is satisfied
branch_stall  out  1  hold IF/ID; the branch must not resolve this cycle

Behaviour:
- Reset:
  - When rst_n=0 at a clk edge, flags <= 3'b000, overriding all other inputs.
  - cond_met and branch_stall are combinational and follow from flags=0 and the inputs.
- Commit:
  - commit = ex_valid & ~stall_in & ~flush & rst_n.
  - On commit, each flag whose we bit is 1 updates; flags whose we bit is 0 hold.
  - Next-value definitions: Z = (ex_result == 0); N = ex_result[WIDTH-1]; V = ex_ovf.
  - Flags take effect one cycle after commit (registered).
- Effective flags (fe):
  - BYPASS=0: fe = flags.
  - BYPASS=1: fe = the flags value that would be written this cycle if commit were 1, computed bitwise from we/next/flags; otherwise fe = flags.
- cond_met from fe (Z=fe[0], V=fe[1], N=fe[2]):
  - 000 NE: ~Z
  - 001 EQ: Z
  - 010 GT: ~Z & ~N
  - 011 LT: N
  - 100 GE: Z | (~Z & ~N)
  - 101 LE: N | Z
  - 110 OV: V
  - 111 UN: 1
  - cond_met is valid regardless of id_branch. The consumer gates it.
- Hazard (BYPASS=0):
  - branch_stall = id_branch & ex_valid & ~flush & (|ex_flag_we).
  - The ID branch is held; the writer commits at the edge; next cycle the EX stage contains a bubble from the ID hold, so the stall drops and cond_met uses the new flags.
  - If stall_in=1, branch_stall stays asserted for as long as the writer remains uncommitted in EX.
- Hazard (BYPASS=1): branch_stall is tied 0.
- Writer with ex_flag_we=000: no hazard, no flag change.
- Flush and write in the same cycle: the write is dropped and there is no stall.
- Reset mid-stall: flags clear, and the stall follows the combinational inputs on the next cycle.
- No internal state other than the 3 flag bits. No X propagation: every output is defined for all inputs after reset.

Test Plan:
1. rst_n=0 for 2 cycles, then id_branch=1 with id_cond=001 → flags=000, cond_met=0. With id_cond=000 → cond_met=1. With id_cond=111 → cond_met=1.
2. Commit ex_result=16'h0000, ex_flag_we=111, ex_ovf=0 → next cycle flags=001. id_cond=001 → cond_met=1; id_cond=010 → cond_met=0. Then commit ex_result=16'h8000 with we=001 only → flags=000 (Z cleared, N unchanged at 0).
3. Commit ex_result=16'h8001, ex_ovf=1, we=111 → flags=110. id_cond=011 → 1; 110 → 1; 101 → 1; 100 → 0.
4. BYPASS=0: id_branch=1 while ex_valid=1 and we=001 → branch_stall=1 for exactly 1 cycle. Add stall_in=1 for 3 cycles → branch_stall=1 for 4 cycles and flags unchanged until the commit edge.
5. flush=1 with ex_valid=1, we=111, ex_result=0 → flags unchanged, branch_stall=0.
6. BYPASS=1: flags=000, EX commits ex_result=0 with we=001, id_cond=001 in the same cycle → cond_met=1 that cycle, branch_stall=0, flags=001 next cycle.

Source files
------------

// File: rtl/flag_unit.sv
// flag_unit
//   Holds the architectural Z/V/N condition flags written by the EX-stage ALU
//   and evaluates the 3-bit branch condition for the branch sitting in ID.
//   A flag-writing instruction in EX makes the ID branch outcome stale. With
//   BYPASS=0 the branch is stalled for that cycle. With BYPASS=1 the
//   about-to-be-written flags are forwarded to the condition evaluator.
//
// Parameters
//   WIDTH   ALU result width
//   BYPASS  0: stall the ID branch behind an EX flag writer
//           1: forward EX flags combinationally, never stall
//
// Ports
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset (clears flags)
//   stall_in      global pipeline hold; EX does not commit while high
//   flush         squash the EX instruction (no flag write)
//   ex_valid      EX holds a valid instruction
//   ex_flag_we    per-flag write enable {N,V,Z}
//   ex_result     ALU result of the EX instruction
//   ex_ovf        signed overflow from the ALU
//   id_branch     ID holds a conditional branch
//   id_cond       condition code of the ID branch
//   flags         registered flags {N,V,Z}
//   cond_met      condition id_cond holds against the effective flags
//   branch_stall  hold IF/ID; the branch must not resolve this cycle
//
// Handshake: there is no valid/ready pair here. A flag writer is "accepted"
// on the rising edge where commit (ex_valid & ~stall_in & ~flush & rst_n) is
// high; branch_stall tells ID its branch may not resolve in the current cycle.
module flag_unit #(
  parameter int WIDTH  = 16,
  parameter bit BYPASS = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_in,
  input  logic             flush,
  input  logic             ex_valid,
  input  logic [2:0]       ex_flag_we,
  input  logic [WIDTH-1:0] ex_result,
  input  logic             ex_ovf,
  input  logic             id_branch,
  input  logic [2:0]       id_cond,
  output logic [2:0]       flags,
  output logic             cond_met,
  output logic             branch_stall
);

  // Condition codes
  localparam logic [2:0] COND_NE = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_GT = 3'b010;
  localparam logic [2:0] COND_LT = 3'b011;
  localparam logic [2:0] COND_GE = 3'b100;
  localparam logic [2:0] COND_LE = 3'b101;
  localparam logic [2:0] COND_OV = 3'b110;
  localparam logic [2:0] COND_UN = 3'b111;

  logic       commit;
  logic [2:0] next_flags;
  logic [2:0] write_flags;
  logic [2:0] fe;
  logic       fz;
  logic       fv;
  logic       fn;

  assign commit     = ex_valid & ~stall_in & ~flush & rst_n;
  assign next_flags = {ex_result[WIDTH-1], ex_ovf, (ex_result == '0)};

  // Per-flag merge: enabled bits take the new value, the rest hold.
  assign write_flags = (ex_flag_we & next_flags) | (~ex_flag_we & flags);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags <= 3'b000;
    end else if (commit) begin
      flags <= write_flags;
    end
  end

  // Effective flags seen by the condition evaluator.
  always_comb begin
    fe = flags;
    if (BYPASS && commit) begin
      fe = write_flags;
    end
  end

  assign fz = fe[0];
  assign fv = fe[1];
  assign fn = fe[2];

  always_comb begin
    cond_met = 1'b0;
    unique case (id_cond)
      COND_NE: cond_met = ~fz;
      COND_EQ: cond_met = fz;
      COND_GT: cond_met = ~fz & ~fn;
      COND_LT: cond_met = fn;
      COND_GE: cond_met = fz | (~fz & ~fn);
      COND_LE: cond_met = fn | fz;
      COND_OV: cond_met = fv;
      COND_UN: cond_met = 1'b1;
      default: cond_met = 1'b0;
    endcase
  end

  // The stall does not look at stall_in: a writer held in EX by a global
  // stall keeps the branch held until the writer actually commits.
  always_comb begin
    branch_stall = 1'b0;
    if (!BYPASS) begin
      branch_stall = id_branch & ex_valid & ~flush & (|ex_flag_we);
    end
  end

endmodule

// File: tb/tb_flag_unit.sv
// Testbench for flag_unit. Two instances (BYPASS=0 and BYPASS=1) share the
// same stimulus; their registered flags are always identical, only the
// combinational outputs differ.
module tb_flag_unit;

  localparam int WIDTH = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  logic             rst_n;
  logic             stall_in;
  logic             flush;
  logic             ex_valid;
  logic [2:0]       ex_flag_we;
  logic [WIDTH-1:0] ex_result;
  logic             ex_ovf;
  logic             id_branch;
  logic [2:0]       id_cond;

  logic [2:0] flags0, flags1;
  logic       cond0, cond1;
  logic       stall0, stall1;

  flag_unit #(.WIDTH(WIDTH), .BYPASS(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .flush(flush),
    .ex_valid(ex_valid), .ex_flag_we(ex_flag_we), .ex_result(ex_result),
    .ex_ovf(ex_ovf), .id_branch(id_branch), .id_cond(id_cond),
    .flags(flags0), .cond_met(cond0), .branch_stall(stall0)
  );

  flag_unit #(.WIDTH(WIDTH), .BYPASS(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .flush(flush),
    .ex_valid(ex_valid), .ex_flag_we(ex_flag_we), .ex_result(ex_result),
    .ex_ovf(ex_ovf), .id_branch(id_branch), .id_cond(id_cond),
    .flags(flags1), .cond_met(cond1), .branch_stall(stall1)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic             rst_n;
    logic             stall_in;
    logic             flush;
    logic             ex_valid;
    logic [2:0]       we;
    logic [WIDTH-1:0] result;
    logic             ovf;
    logic             id_branch;
    logic [2:0]       cond;
    logic             chk;
    logic [2:0]       e_flags;  // flags before this cycle's edge
    logic             e_c0;
    logic             e_s0;
    logic             e_c1;
    logic             e_s1;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic si, input logic fl,
                     input logic v, input logic [2:0] we,
                     input logic [WIDTH-1:0] res, input logic ovf,
                     input logic br, input logic [2:0] cond, input logic chk,
                     input logic [2:0] ef, input logic c0, input logic s0,
                     input logic c1, input logic s1);
    vec_t t;
    t.rst_n = r; t.stall_in = si; t.flush = fl; t.ex_valid = v; t.we = we;
    t.result = res; t.ovf = ovf; t.id_branch = br; t.cond = cond; t.chk = chk;
    t.e_flags = ef; t.e_c0 = c0; t.e_s0 = s0; t.e_c1 = c1; t.e_s1 = s1;
    vecs.push_back(t);
  endtask

  // ---------------- scoreboard ----------------
  logic [6:0] exp_q[$];  // {flags, cond0, stall0, cond1, stall1}
  int tests = 0;
  int fails = 0;

  task automatic check1(input string name, input logic [2:0] act,
                        input logic [2:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare(input int idx);
    logic [6:0] e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1 at step %0d", idx);
      return;
    end
    e = exp_q.pop_front();
    check1($sformatf("flags0[%0d]", idx), flags0, e[6:4]);
    check1($sformatf("flags1[%0d]", idx), flags1, e[6:4]);
    check1($sformatf("cond0[%0d]", idx), {2'b00, cond0}, {2'b00, e[3]});
    check1($sformatf("stall0[%0d]", idx), {2'b00, stall0}, {2'b00, e[2]});
    check1($sformatf("cond1[%0d]", idx), {2'b00, cond1}, {2'b00, e[1]});
    check1($sformatf("stall1[%0d]", idx), {2'b00, stall1}, {2'b00, e[0]});
  endtask

  // ---------------- driver ----------------
  task automatic drive(input vec_t t);
    @(negedge clk);
    rst_n = t.rst_n; stall_in = t.stall_in; flush = t.flush;
    ex_valid = t.ex_valid; ex_flag_we = t.we; ex_result = t.result;
    ex_ovf = t.ovf; id_branch = t.id_branch; id_cond = t.cond;
    if (t.chk) exp_q.push_back({t.e_flags, t.e_c0, t.e_s0, t.e_c1, t.e_s1});
  endtask

  // ---------------- test ----------------
  initial begin
    logic [7:0] cond_tab;
    rst_n = 1'b0; stall_in = 1'b0; flush = 1'b0; ex_valid = 1'b0;
    ex_flag_we = 3'b000; ex_result = '0; ex_ovf = 1'b0;
    id_branch = 1'b0; id_cond = 3'b000;

    //   rst si fl v  we      result    ovf br cond  chk  flags  c0 s0 c1 s1
    // reset, conditions against flags=000
    add(0, 0, 0, 0, 3'b000, 16'h0000, 0, 1, 3'b001, 0, 3'b000, 0, 0, 0, 0);
    add(0, 0, 0, 0, 3'b000, 16'h0000, 0, 1, 3'b001, 1, 3'b000, 0, 0, 0, 0);
    add(1, 0, 0, 0, 3'b000, 16'h0000, 0, 1, 3'b000, 1, 3'b000, 1, 0, 1, 0);
    add(1, 0, 0, 0, 3'b000, 16'h0000, 0, 1, 3'b111, 1, 3'b000, 1, 0, 1, 0);
    // commit zero result, all flags
    add(1, 0, 0, 1, 3'b111, 16'h0000, 0, 0, 3'b001, 1, 3'b000, 0, 0, 1, 0);
    add(1, 0, 0, 0, 3'b000, 16'h0000, 0, 1, 3'b001, 1, 3'b001, 1, 0, 1, 0);
    add(1, 0, 0, 0, 3'b000, 16'h0000, 0, 1, 3'b010, 1, 3'b001, 0, 0, 0, 0);
    // Z-only write of a negative value: N must stay 0
    add(1, 0, 0, 1, 3'b001, 16'h8000, 0, 0, 3'b001, 1, 3'b001, 1, 0, 0, 0);
    add(1, 0, 0, 0, 3'b000, 16'h0000, 0, 1, 3'b001, 1, 3'b000, 0, 0, 0, 0);
    // negative with overflow
    add(1, 0, 0, 1, 3'b111, 16'h8001, 1, 0, 3'b011, 1, 3'b000, 0, 0, 1, 0);
    add(1, 0, 0, 0, 3'b000, 16'h0000, 0, 1, 3'b011, 1, 3'b110, 1, 0, 1, 0);
    add(1, 0, 0, 0, 3'b000, 16'h0000, 0, 1, 3'b110, 1, 3'b110, 1, 0, 1, 0);
    add(1, 0, 0, 0, 3'b000, 16'h0000, 0, 1, 3'b101, 1, 3'b110, 1, 0, 1, 0);
    add(1, 0, 0, 0, 3'b000, 16'h0000, 0, 1, 3'b100, 1, 3'b110, 0, 0, 0, 0);
    // hazard: one-cycle stall behind a Z writer
    add(1, 0, 0, 1, 3'b001, 16'h0000, 0, 1, 3'b001, 1, 3'b110, 0, 1, 1, 0);
    add(1, 0, 0, 0, 3'b000, 16'h0000, 0, 1, 3'b001, 1, 3'b111, 1, 0, 1, 0);
    // hazard held by stall_in for 3 cycles, commits on the 4th
    add(1, 1, 0, 1, 3'b001, 16'h1234, 0, 1, 3'b001, 1, 3'b111, 1, 1, 1, 0);
    add(1, 1, 0, 1, 3'b001, 16'h1234, 0, 1, 3'b001, 1, 3'b111, 1, 1, 1, 0);
    add(1, 1, 0, 1, 3'b001, 16'h1234, 0, 1, 3'b001, 1, 3'b111, 1, 1, 1, 0);
    add(1, 0, 0, 1, 3'b001, 16'h1234, 0, 1, 3'b001, 1, 3'b111, 1, 1, 0, 0);
    add(1, 0, 0, 0, 3'b000, 16'h0000, 0, 1, 3'b001, 1, 3'b110, 0, 0, 0, 0);
    // flush drops the write and the stall
    add(1, 0, 1, 1, 3'b111, 16'h0000, 0, 1, 3'b001, 1, 3'b110, 0, 0, 0, 0);
    add(1, 0, 0, 0, 3'b000, 16'h0000, 0, 1, 3'b001, 1, 3'b110, 0, 0, 0, 0);
    // writer with no enables: no hazard, no change
    add(1, 0, 0, 1, 3'b000, 16'h0000, 0, 1, 3'b011, 1, 3'b110, 1, 0, 1, 0);
    add(1, 0, 0, 0, 3'b000, 16'h0000, 0, 1, 3'b011, 1, 3'b110, 1, 0, 1, 0);
    // reset mid-stall, then bypass of a Z write from flags=000
    add(0, 0, 0, 1, 3'b001, 16'h0000, 0, 1, 3'b001, 1, 3'b110, 0, 1, 0, 0);
    add(1, 0, 0, 1, 3'b001, 16'h0000, 0, 1, 3'b001, 1, 3'b000, 0, 1, 1, 0);
    add(1, 0, 0, 0, 3'b000, 16'h0000, 0, 1, 3'b001, 1, 3'b001, 1, 0, 1, 0);
    // V-only write
    add(1, 0, 0, 1, 3'b010, 16'h0005, 1, 0, 3'b110, 1, 3'b001, 0, 0, 1, 0);
    add(1, 0, 0, 0, 3'b000, 16'h0000, 0, 1, 3'b110, 1, 3'b011, 1, 0, 1, 0);
    add(1, 0, 0, 0, 3'b000, 16'h0000, 0, 1, 3'b000, 1, 3'b011, 0, 0, 0, 0);
    add(1, 0, 0, 0, 3'b000, 16'h0000, 0, 1, 3'b100, 1, 3'b011, 1, 0, 1, 0);

    foreach (vecs[i]) begin
      drive(vecs[i]);
      #1;
      if (vecs[i].chk) compare(i);
    end

    // Random non-committing cycles: flags hold at 011 (Z=1,V=1,N=0).
    // Conditions NE..UN against 011: 0,1,0,0,1,1,1,1.
    cond_tab = 8'b1111_0010;
    for (int k = 0; k < 40; k++) begin
      vec_t t;
      int mode;
      mode = $urandom_range(0, 2);
      t.rst_n     = 1'b1;
      t.ex_valid  = (mode == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      t.stall_in  = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      t.flush     = (mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
      if (mode == 1 || mode == 2) t.ex_valid = 1'b1;
      t.we        = 3'($urandom_range(0, 7));
      t.result    = 16'($urandom_range(0, 65535));
      t.ovf       = 1'($urandom_range(0, 1));
      t.id_branch = 1'($urandom_range(0, 1));
      t.cond      = 3'($urandom_range(0, 7));
      t.chk       = 1'b1;
      t.e_flags   = 3'b011;
      t.e_c0      = cond_tab[t.cond];
      t.e_c1      = cond_tab[t.cond];
      t.e_s0      = t.id_branch & t.ex_valid & ~t.flush & (t.we != 3'b000);
      t.e_s1      = 1'b0;
      drive(t);
      #1;
      compare(vecs.size() + k);
    end

    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
